// File: rtl/sr_cmd_if.sv
// Command bus between a request source and sr_cmd_conditioner.
// Raw request lines in, conditioned s/r drive and status out.
interface sr_cmd_if;
    logic set_raw;
    logic clr_raw;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_raw,
        output clr_raw,
        input  s,
        input  r,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_raw,
        input  clr_raw,
        output s,
        output r,
        output busy,
        output conflict
    );
endinterface

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw async set/clear requests into clean registered
// s/r pulses: sync, debounce, edge detect, arbitrate, pulse.
module sr_cmd_conditioner #(
    parameter int unsigned DB_CYCLES      = 4,
    parameter int unsigned PULSE_LEN      = 1,
    parameter bit          PRIORITY_RESET = 1'b1
) (
    input logic     clk,
    input logic     rst_n,
    sr_cmd_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        DRIVE_S,
        DRIVE_R,
        GAP
    } state_t;

    localparam logic [3:0] DB_MAX = 4'(DB_CYCLES - 1);
    localparam logic [3:0] PL_MAX = 4'(PULSE_LEN - 1);

    // Channel index 0 is set, 1 is clear.
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_db;
    logic [1:0] r_db_d;
    logic [1:0] r_pend;
    logic [3:0] r_cnt [2];
    state_t     r_state;
    logic [3:0] r_pcnt;
    logic       r_s;
    logic       r_r;
    logic       r_busy;
    logic       r_conflict;

    logic [1:0] w_rise;
    logic [1:0] w_req;
    logic [1:0] w_clear;
    state_t     w_next;
    logic [3:0] w_pcnt_nxt;
    logic       w_conflict;

    assign w_rise = r_db & ~r_db_d;
    assign w_req  = r_pend | w_rise;

    // Two-flop synchronizer; the only logic touching the raw lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {bus.clr_raw, bus.set_raw};
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: toggle after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db   <= '0;
            r_db_d <= '0;
            r_cnt  <= '{default: '0};
        end else begin
            r_db_d <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_cnt[i] == DB_MAX) begin
                        r_db[i]  <= ~r_db[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 4'd1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Next state, pulse counter and arbitration decisions.
    always_comb begin
        w_next     = r_state;
        w_pcnt_nxt = r_pcnt;
        w_clear    = 2'b00;
        w_conflict = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_pcnt_nxt = '0;
                if (w_req == 2'b11) begin
                    w_conflict = 1'b1;
                    w_clear    = 2'b11;
                    w_next     = PRIORITY_RESET ? DRIVE_R : DRIVE_S;
                end else if (w_req[0]) begin
                    w_clear = 2'b01;
                    w_next  = DRIVE_S;
                end else if (w_req[1]) begin
                    w_clear = 2'b10;
                    w_next  = DRIVE_R;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (r_pcnt == PL_MAX) begin
                    w_pcnt_nxt = '0;
                    w_next     = GAP;
                end else begin
                    w_pcnt_nxt = r_pcnt + 4'd1;
                end
            end
            GAP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, pending flags and registered outputs move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pcnt     <= '0;
            r_pend     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pcnt     <= w_pcnt_nxt;
            r_pend     <= w_req & ~w_clear;
            r_s        <= (w_next == DRIVE_S);
            r_r        <= (w_next == DRIVE_R);
            r_busy     <= (w_next != IDLE);
            r_conflict <= w_conflict;
        end
    end

    assign bus.s        = r_s;
    assign bus.r        = r_r;
    assign bus.busy     = r_busy;
    assign bus.conflict = r_conflict;
endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: two instances (defaults, and
// PULSE_LEN=3 with set priority) checked by vectors and a model.
module tb_sr_cmd_conditioner;
    logic clk = 1'b0;
    logic rst_n;

    sr_cmd_if ifa ();
    sr_cmd_if ifb ();

    sr_cmd_conditioner u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    sr_cmd_conditioner #(
        .DB_CYCLES      (4),
        .PULSE_LEN      (3),
        .PRIORITY_RESET (1'b0)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit c);
        ifa.set_raw = s;
        ifb.set_raw = s;
        ifa.clr_raw = c;
        ifb.clr_raw = c;
    endtask

    // Reference model: request timing from the raw sample history,
    // command scheduling by timestamps (start edge, free edge).
    int m_db [2] = '{4, 4};
    int m_pl [2] = '{1, 3};
    bit m_pr [2] = '{1'b1, 1'b0};

    bit mh1   [2][2];
    bit mh2   [2][2];
    bit mdb   [2][2];
    bit mdbp  [2][2];
    bit mpend [2][2];
    int mrun  [2][2];
    int mcyc  [2];
    int mstart[2];
    int mfree [2];
    bit mwin  [2];
    bit mconf [2];
    int es [2];
    int er [2];
    int eb [2];
    int ec [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                mh1[i][c]   = 0;
                mh2[i][c]   = 0;
                mdb[i][c]   = 0;
                mdbp[i][c]  = 0;
                mpend[i][c] = 0;
                mrun[i][c]  = 0;
            end
            mstart[i] = -1000;
            mfree[i]  = 0;
            mwin[i]   = 0;
            mconf[i]  = 0;
            es[i] = 0;
            er[i] = 0;
            eb[i] = 0;
            ec[i] = 0;
        end
    endtask

    task automatic model_step();
        bit rw [2];
        bit rise [2];
        bit req [2];
        int n;
        int d;
        rw[0] = ifa.set_raw;
        rw[1] = ifa.clr_raw;
        for (int i = 0; i < 2; i++) begin
            mcyc[i]++;
            n = mcyc[i];
            for (int c = 0; c < 2; c++)
                rise[c] = mdb[i][c] && !mdbp[i][c];
            for (int c = 0; c < 2; c++) begin
                mdbp[i][c] = mdb[i][c];
                // mh2 holds the raw value sampled two edges ago
                if (mh2[i][c] != mdb[i][c]) begin
                    mrun[i][c]++;
                    if (mrun[i][c] >= m_db[i]) begin
                        mdb[i][c]  = !mdb[i][c];
                        mrun[i][c] = 0;
                    end
                end else begin
                    mrun[i][c] = 0;
                end
                mh2[i][c] = mh1[i][c];
                mh1[i][c] = rw[c];
            end
            for (int c = 0; c < 2; c++)
                req[c] = mpend[i][c] || rise[c];
            if (n >= mfree[i] && (req[0] || req[1])) begin
                mconf[i]  = req[0] && req[1];
                mwin[i]   = mconf[i] ? m_pr[i] : req[1];
                mstart[i] = n;
                mfree[i]  = n + m_pl[i] + 2;
                if (mconf[i]) begin
                    req[0] = 0;
                    req[1] = 0;
                end else begin
                    req[mwin[i]] = 0;
                end
            end
            mpend[i][0] = req[0];
            mpend[i][1] = req[1];
            d = n - mstart[i];
            es[i] = (!mwin[i] && d >= 0 && d < m_pl[i]) ? 1 : 0;
            er[i] = ( mwin[i] && d >= 0 && d < m_pl[i]) ? 1 : 0;
            eb[i] = (d >= 0 && d <= m_pl[i]) ? 1 : 0;
            ec[i] = (d == 0 && mconf[i]) ? 1 : 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle comparison against the model plus window counters.
    bit chk_en = 0;
    bit cnt_on = 0;
    int cs [2];
    int cr [2];
    int cb [2];
    int cc [2];

    always @(negedge clk) begin
        int as [2];
        int ar [2];
        int ab [2];
        int ac [2];
        as[0] = ifa.s;  as[1] = ifb.s;
        ar[0] = ifa.r;  ar[1] = ifb.r;
        ab[0] = ifa.busy;  ab[1] = ifb.busy;
        ac[0] = ifa.conflict;  ac[1] = ifb.conflict;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("mdl_s[%0d]", i), as[i], es[i]);
                check($sformatf("mdl_r[%0d]", i), ar[i], er[i]);
                check($sformatf("mdl_busy[%0d]", i), ab[i], eb[i]);
                check($sformatf("mdl_conf[%0d]", i), ac[i], ec[i]);
                check($sformatf("s_and_r[%0d]", i), as[i] & ar[i], 0);
            end
        end
        if (cnt_on) begin
            for (int i = 0; i < 2; i++) begin
                cs[i] += as[i];
                cr[i] += ar[i];
                cb[i] += ab[i];
                cc[i] += ac[i];
            end
        end
    end

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            cs[i] = 0;
            cr[i] = 0;
            cb[i] = 0;
            cc[i] = 0;
        end
    endtask

    typedef struct {
        string nm;
        int set_len;
        int clr_len;
        int clr_dly;
        int a_s, a_r, a_c, a_b;
        int b_s, b_r, b_c, b_b;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{"set20",   20,  0, 0, 1, 0, 0, 2, 3, 0, 0, 4};
        vecs[1] = '{"clr3",     0,  3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{"both10",  10, 10, 0, 0, 1, 1, 2, 3, 0, 1, 4};
        vecs[3] = '{"b2b",     10, 10, 2, 1, 1, 0, 4, 3, 3, 0, 8};
        vecs[4] = '{"set4",     4,  0, 0, 1, 0, 0, 2, 3, 0, 0, 4};
        vecs[5] = '{"set3",     3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{"clr20",    0, 20, 0, 0, 1, 0, 2, 0, 3, 0, 4};

        // Reset held with both requests high: outputs stay low.
        rst_n = 1'b0;
        drive(1, 1);
        @(negedge clk);
        chk_en = 1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("rst_a_any", ifa.s | ifa.r | ifa.busy | ifa.conflict, 0);
            check("rst_b_any", ifb.s | ifb.r | ifb.busy | ifb.conflict, 0);
        end
        drive(0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_a_busy", ifa.busy, 0);

        // Exact latency: raw sampled at edge k -> s after edge k+6.
        drive(1, 0);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_a_s_j%0d", j), ifa.s, (j == 6) ? 1 : 0);
            check($sformatf("lat_b_s_j%0d", j), ifb.s,
                  (j >= 6 && j <= 8) ? 1 : 0);
        end
        repeat (15) @(negedge clk);
        drive(0, 0);
        repeat (20) @(negedge clk);

        // Table of patterns, counting asserted cycles per window.
        foreach (vecs[v]) begin
            clr_counts();
            cnt_on = 1;
            for (int t = 0; t < 70; t++) begin
                drive(t < vecs[v].set_len,
                      t >= vecs[v].clr_dly &&
                      t < vecs[v].clr_dly + vecs[v].clr_len);
                @(negedge clk);
            end
            cnt_on = 0;
            check({vecs[v].nm, "_a_s"}, cs[0], vecs[v].a_s);
            check({vecs[v].nm, "_a_r"}, cr[0], vecs[v].a_r);
            check({vecs[v].nm, "_a_conf"}, cc[0], vecs[v].a_c);
            check({vecs[v].nm, "_a_busy"}, cb[0], vecs[v].a_b);
            check({vecs[v].nm, "_b_s"}, cs[1], vecs[v].b_s);
            check({vecs[v].nm, "_b_r"}, cr[1], vecs[v].b_r);
            check({vecs[v].nm, "_b_conf"}, cc[1], vecs[v].b_c);
            check({vecs[v].nm, "_b_busy"}, cb[1], vecs[v].b_b);
        end

        // Reset in the 2nd cycle of a 3-cycle s pulse drops s at once.
        drive(1, 0);
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            if (j == 7) begin
                #2;
                check("midrst_b_s_before", ifb.s, 1);
                rst_n = 1'b0;
                #1;
                check("midrst_b_s_after", ifb.s, 0);
                check("midrst_b_busy_after", ifb.busy, 0);
            end
        end
        @(negedge clk);
        drive(0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr_counts();
        cnt_on = 1;
        repeat (20) @(negedge clk);
        cnt_on = 0;
        check("midrst_b_s_cnt", cs[1], 0);
        check("midrst_b_busy_cnt", cb[1], 0);
        check("midrst_a_busy_cnt", cb[0], 0);

        // Random request traffic checked against the model.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        drive(0, 0);
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
